cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Moore FSM that sequences the 8-bit CPU datapath through fetch, decode and execute for every opcode in the instruction set.
- Drives the register load strobes, bus selects, the ALU select and the memory write strobe.
- Accounts for the one-cycle registered read latency of the synchronous 128x8 program ROM and the RAM/IO memory map.
- Sits beside the datapath: it reads IR and the CCR flags, and it drives control signals only.

Parameters:
- ALU_SEL_W, 4, width of ALU_Sel.
- STATE_W, 5, width of the state register. Must hold all encoded states.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- IR  input  8  instruction register contents from the datapath.
- CCR_Result  input  4  flags {N,Z,V,C}.
- IR_Load  output  1  load IR from Bus2.
- MAR_Load  output  1  load MAR from Bus2.
- PC_Load  output  1  load PC from Bus2.
- PC_Inc  output  1  PC <= PC+1.
- A_Load  output  1  load A from Bus2.
- B_Load  output  1  load B from Bus2.
- CCR_Load  output  1  load CCR from the ALU flags.
- ALU_Sel  output  ALU_SEL_W  ALU operation code.
- Bus1_Sel  output  2  Bus1 source: 0=PC, 1=A, 2=B, 3=result latch.
- Bus2_Sel  output  2  Bus2 source: 0=ALU_Result, 1=Bus1, 2=from_memory.
- write  output  1  memory write strobe; memory writes Bus1 to [MAR].
- halted  output  1  high while in S_HALT. Tied 0 unless HALT_ON_ILLEGAL_EN is defined.

Behaviour:
- Outputs are a pure combinational decode of the current state (Moore). Any output not listed for a state is 0.
- Reset:
  - reset=0 forces the state to S_FETCH_0 immediately.
  - The outputs therefore show the S_FETCH_0 decode: MAR_Load=1, Bus1_Sel=0, Bus2_Sel=1, all else 0, halted=0.
  - Reset asserted mid-instruction aborts it. No write pulse may occur after reset is asserted.
- Fetch, 3 cycles:
  - S_FETCH_0: MAR<=PC (Bus1_Sel=0, Bus2_Sel=1, MAR_Load).
  - S_FETCH_1: PC_Inc. This is also the ROM latency cycle.
  - S_FETCH_2: Bus2_Sel=2, IR_Load.
- S_DECODE_3: no strobes. Branches on IR; unlisted opcodes take the illegal path.
- LDA_IMM 86 / LDB_IMM 88:
  - MAR<=PC, then PC_Inc.
  - Then Bus2_Sel=2 with A_Load or B_Load.
  - 3 execute states.
- LDA_DIR 87 / LDB_DIR 89:
  - MAR<=PC, then PC_Inc.
  - Then Bus2_Sel=2 with MAR_Load.
  - Then one wait state.
  - Then Bus2_Sel=2 with A_Load or B_Load.
  - 5 execute states.
- STA_DIR 96 / STB_DIR 97 / STR_DIR 98:
  - MAR<=PC, then PC_Inc.
  - Then Bus2_Sel=2 with MAR_Load.
  - Then write=1 with Bus1_Sel=1 (A), 2 (B) or 3 (result latch).
  - 4 execute states. write is high for exactly one cycle.
- ALU ops, 1 execute state: ALU_Sel=code, Bus2_Sel=0, CCR_Load=1, plus the destination load.
  - A_Load destination, codes: ADD 42=0, SUB 43=1, AND 44=2, OR 45=3, INCA 46=4, DECA 48=5, XOR 4A=6, NOTA 4B=7.
  - B_Load destination, codes: INCB 4C=8, DECB 4D=9, NOTB 4E=10, SUB_BA 4F=11.
- Branches 20–28:
  - Conditions: BRA always; BMI N=1; BPL N=0; BEQ Z=1; BNE Z=0; BVS V=1; BVC V=0; BCS C=1; BCC C=0.
  - Condition is sampled in S_DECODE_3.
  - Taken: MAR<=PC, then wait, then Bus2_Sel=2 with PC_Load. 3 execute states.
  - Not taken: one state with PC_Inc, which skips the operand. 1 execute state.
- After the last execute state the FSM always returns to S_FETCH_0.
- Illegal opcode: one no-op state, then S_FETCH_0. The PC is not incremented further.
- Flags are read only in S_DECODE_3. Changes in other states are ignored.

Optional Feature:
- Macro: HALT_ON_ILLEGAL_EN.
- Defined:
  - An illegal opcode enters S_HALT: all strobes 0, halted=1.
  - The FSM stays in S_HALT until reset.
- Undefined:
  - An illegal opcode is a one-cycle no-op.
  - S_HALT does not exist and halted is constant 0.

Test Plan:
- Program LDA_IMM AA; STA_DIR E0; BRA 00 -> write pulses once every 22 cycles (7+8+7), with Bus1_Sel=1 during write. The loop repeats indefinitely.
- IR=42 after fetch -> exactly one cycle with ALU_Sel=0, Bus2_Sel=0, A_Load=1, CCR_Load=1. Instruction total is 5 cycles.
- BEQ with Z=0 -> PC_Inc is asserted twice in the instruction (fetch + skip) and PC_Load is never asserted. BEQ with Z=1 -> PC_Load is asserted once, in the 7th cycle.
- LDB_DIR -> MAR_Load is asserted 3 times and B_Load once, in the 9th cycle. A_Load stays 0.
- Drive reset low during the STA_DIR MAR-load state -> the state becomes S_FETCH_0 immediately. write never pulses. After release, fetch restarts.
- IR=FF -> with the macro undefined, the next S_FETCH_0 comes after 5 cycles. With the macro defined, halted=1 and stays high until reset, with no strobes.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Moore fetch/decode/execute sequencer for the 8-bit CPU datapath.
// Optional macro HALT_ON_ILLEGAL_EN: illegal opcodes park the FSM in S_HALT.
module cpu_control_unit #(
  parameter int ALU_SEL_W = 4,
  parameter int STATE_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           IR,
  input  logic [3:0]           CCR_Result,
  output logic                 IR_Load,
  output logic                 MAR_Load,
  output logic                 PC_Load,
  output logic                 PC_Inc,
  output logic                 A_Load,
  output logic                 B_Load,
  output logic                 CCR_Load,
  output logic [ALU_SEL_W-1:0] ALU_Sel,
  output logic [1:0]           Bus1_Sel,
  output logic [1:0]           Bus2_Sel,
  output logic                 write,
  output logic                 halted
);

  localparam logic [7:0] LDA_IMM = 8'h86;
  localparam logic [7:0] LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88;
  localparam logic [7:0] LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96;
  localparam logic [7:0] STB_DIR = 8'h97;
  localparam logic [7:0] STR_DIR = 8'h98;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_OPR_MAR, S_OPR_INC, S_DIR_MAR, S_DIR_WAIT,
    S_LDA, S_LDB, S_STA, S_STB, S_STR,
    S_BR_WAIT, S_BR_LOAD, S_BR_SKIP,
    S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA,
    S_XOR, S_NOTA, S_INCB, S_DECB, S_NOTB, S_SUBBA,
`ifdef HALT_ON_ILLEGAL_EN
    S_HALT
`else
    S_ILLEGAL
`endif
  } state_t;

  state_t state, state_nxt;
  logic   br_take;

  wire n_f = CCR_Result[3];
  wire z_f = CCR_Result[2];
  wire v_f = CCR_Result[1];
  wire c_f = CCR_Result[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH_0;
    else        state <= state_nxt;
  end

  always_comb begin
    br_take = 1'b0;
    case (IR)
      8'h20: br_take = 1'b1;
      8'h21: br_take = n_f;
      8'h22: br_take = !n_f;
      8'h23: br_take = z_f;
      8'h24: br_take = !z_f;
      8'h25: br_take = v_f;
      8'h26: br_take = !v_f;
      8'h27: br_take = c_f;
      8'h28: br_take = !c_f;
      default: br_take = 1'b0;
    endcase
  end

  // Operand states are shared; IR stays stable until the next fetch
  always_comb begin
    state_nxt = S_FETCH_0;
    unique case (state)
      S_FETCH_0: state_nxt = S_FETCH_1;
      S_FETCH_1: state_nxt = S_FETCH_2;
      S_FETCH_2: state_nxt = S_DECODE_3;
      S_DECODE_3: begin
        case (IR)
          LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR,
          STA_DIR, STB_DIR, STR_DIR:
            state_nxt = S_OPR_MAR;
          8'h42: state_nxt = S_ADD;
          8'h43: state_nxt = S_SUB;
          8'h44: state_nxt = S_AND;
          8'h45: state_nxt = S_OR;
          8'h46: state_nxt = S_INCA;
          8'h48: state_nxt = S_DECA;
          8'h4A: state_nxt = S_XOR;
          8'h4B: state_nxt = S_NOTA;
          8'h4C: state_nxt = S_INCB;
          8'h4D: state_nxt = S_DECB;
          8'h4E: state_nxt = S_NOTB;
          8'h4F: state_nxt = S_SUBBA;
          8'h20, 8'h21, 8'h22, 8'h23, 8'h24,
          8'h25, 8'h26, 8'h27, 8'h28:
            state_nxt = br_take ? S_OPR_MAR : S_BR_SKIP;
`ifdef HALT_ON_ILLEGAL_EN
          default: state_nxt = S_HALT;
`else
          default: state_nxt = S_ILLEGAL;
`endif
        endcase
      end
      S_OPR_MAR: begin
        if (IR[7:4] == 4'h2) state_nxt = S_BR_WAIT;
        else                 state_nxt = S_OPR_INC;
      end
      S_OPR_INC: begin
        if (IR == LDA_IMM)      state_nxt = S_LDA;
        else if (IR == LDB_IMM) state_nxt = S_LDB;
        else                    state_nxt = S_DIR_MAR;
      end
      S_DIR_MAR: begin
        if (IR == STA_DIR)      state_nxt = S_STA;
        else if (IR == STB_DIR) state_nxt = S_STB;
        else if (IR == STR_DIR) state_nxt = S_STR;
        else                    state_nxt = S_DIR_WAIT;
      end
      S_DIR_WAIT: begin
        if (IR == LDA_DIR) state_nxt = S_LDA;
        else               state_nxt = S_LDB;
      end
      S_BR_WAIT: state_nxt = S_BR_LOAD;
`ifdef HALT_ON_ILLEGAL_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_FETCH_0;
    endcase
  end

  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = '0;
    Bus1_Sel = 2'd0;
    Bus2_Sel = 2'd0;
    write    = 1'b0;
    halted   = 1'b0;
    unique case (state)
      S_FETCH_0, S_OPR_MAR: begin
        Bus1_Sel = 2'd0;
        Bus2_Sel = 2'd1;
        MAR_Load = 1'b1;
      end
      S_FETCH_1, S_OPR_INC, S_BR_SKIP: PC_Inc = 1'b1;
      S_FETCH_2: begin
        Bus2_Sel = 2'd2;
        IR_Load  = 1'b1;
      end
      S_DIR_MAR: begin
        Bus2_Sel = 2'd2;
        MAR_Load = 1'b1;
      end
      S_LDA: begin
        Bus2_Sel = 2'd2;
        A_Load   = 1'b1;
      end
      S_LDB: begin
        Bus2_Sel = 2'd2;
        B_Load   = 1'b1;
      end
      S_STA: begin
        Bus1_Sel = 2'd1;
        write    = 1'b1;
      end
      S_STB: begin
        Bus1_Sel = 2'd2;
        write    = 1'b1;
      end
      S_STR: begin
        Bus1_Sel = 2'd3;
        write    = 1'b1;
      end
      S_BR_LOAD: begin
        Bus2_Sel = 2'd2;
        PC_Load  = 1'b1;
      end
      S_ADD, S_SUB, S_AND, S_OR, S_INCA,
      S_DECA, S_XOR, S_NOTA: begin
        CCR_Load = 1'b1;
        A_Load   = 1'b1;
      end
      S_INCB, S_DECB, S_NOTB, S_SUBBA: begin
        CCR_Load = 1'b1;
        B_Load   = 1'b1;
      end
`ifdef HALT_ON_ILLEGAL_EN
      S_HALT: halted = 1'b1;
`endif
      default: ;
    endcase
    unique case (state)
      S_SUB:   ALU_Sel = ALU_SEL_W'(1);
      S_AND:   ALU_Sel = ALU_SEL_W'(2);
      S_OR:    ALU_Sel = ALU_SEL_W'(3);
      S_INCA:  ALU_Sel = ALU_SEL_W'(4);
      S_DECA:  ALU_Sel = ALU_SEL_W'(5);
      S_XOR:   ALU_Sel = ALU_SEL_W'(6);
      S_NOTA:  ALU_Sel = ALU_SEL_W'(7);
      S_INCB:  ALU_Sel = ALU_SEL_W'(8);
      S_DECB:  ALU_Sel = ALU_SEL_W'(9);
      S_NOTB:  ALU_Sel = ALU_SEL_W'(10);
      S_SUBBA: ALU_Sel = ALU_SEL_W'(11);
      default: ALU_Sel = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit.
// Define HALT_ON_ILLEGAL_EN to check the halting variant.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc;
  logic       A_Load, B_Load, CCR_Load;
  logic [3:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write, halted;

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .IR(IR),
    .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load),
    .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load),
    .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
    .write(write), .halted(halted)
  );

  always #5 clk = ~clk;

  wire [16:0] ctl = {IR_Load, MAR_Load, PC_Load,
    PC_Inc, A_Load, B_Load, CCR_Load, ALU_Sel,
    Bus1_Sel, Bus2_Sel, write, halted};

  function automatic logic [16:0] mk(
    input logic ir_l, mar_l, pc_l, pc_i,
    input logic a_l, b_l, ccr_l,
    input logic [3:0] alu,
    input logic [1:0] b1, b2,
    input logic wr, h);
    return {ir_l, mar_l, pc_l, pc_i, a_l, b_l,
      ccr_l, alu, b1, b2, wr, h};
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
    input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
        tag, got, exp);
    end
  endtask

  int n_wr, n_inc, n_pld, n_mar, n_ald, n_bld;
  int n_halt, c_wr, c_pld, c_bld, b1_wr;
  logic [16:0] last;
  logic [16:0] f0;

  // One instruction, n cycles, sampled on falling edges
  task automatic run(input logic [7:0] op,
    input logic [3:0] fl, input int n);
    IR = op;
    CCR_Result = fl;
    n_wr = 0; n_inc = 0; n_pld = 0; n_mar = 0;
    n_ald = 0; n_bld = 0; n_halt = 0;
    c_wr = 0; c_pld = 0; c_bld = 0; b1_wr = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1)
        chk($sformatf("fetch0_%h", op), ctl, f0);
      if (i == 5) CCR_Result = ~fl;
      if (write) begin
        n_wr++; c_wr = i; b1_wr = Bus1_Sel;
      end
      if (PC_Inc) n_inc++;
      if (PC_Load) begin n_pld++; c_pld = i; end
      if (MAR_Load) n_mar++;
      if (A_Load) n_ald++;
      if (B_Load) begin n_bld++; c_bld = i; end
      if (halted) n_halt++;
      last = ctl;
    end
  endtask

  int w_abort;
  int loop_wr;

  initial begin
    f0 = mk(0,1,0,0,0,0,0,4'd0,2'd0,2'd1,0,0);
    reset = 1'b0;
    IR = 8'h00;
    CCR_Result = 4'h0;
    #1 chk("reset_decode", ctl, f0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int k = 0; k < 2; k++) begin
      loop_wr = 0;
      run(8'h86, 4'h0, 7);
      chk("lda_imm_aload", n_ald, 1);
      loop_wr += n_wr;
      run(8'h96, 4'h0, 8);
      chk("sta_wr_cycle", c_wr, 8);
      chk("sta_wr_bus1", b1_wr, 1);
      loop_wr += n_wr;
      run(8'h20, 4'h0, 7);
      chk("bra_pcload", c_pld, 7);
      loop_wr += n_wr;
      chk($sformatf("loop%0d_writes", k), loop_wr, 1);
    end

    run(8'h42, 4'h0, 5);
    chk("add_exec", last,
      mk(0,0,0,0,1,0,1,4'd0,2'd0,2'd0,0,0));
    chk("add_aload_cnt", n_ald, 1);
    run(8'h4A, 4'h0, 5);
    chk("xor_exec", last,
      mk(0,0,0,0,1,0,1,4'd6,2'd0,2'd0,0,0));
    run(8'h4F, 4'h0, 5);
    chk("subba_exec", last,
      mk(0,0,0,0,0,1,1,4'd11,2'd0,2'd0,0,0));

    run(8'h23, 4'b0000, 5);
    chk("beq_nt_inc", n_inc, 2);
    chk("beq_nt_pld", n_pld, 0);
    run(8'h23, 4'b0100, 7);
    chk("beq_t_pld", n_pld, 1);
    chk("beq_t_cyc", c_pld, 7);
    chk("beq_t_inc", n_inc, 1);
    run(8'h28, 4'b0001, 5);
    chk("bcc_nt_pld", n_pld, 0);
    run(8'h21, 4'b1000, 7);
    chk("bmi_t_cyc", c_pld, 7);

    run(8'h89, 4'h0, 9);
    chk("ldb_dir_mar", n_mar, 3);
    chk("ldb_dir_bld", n_bld, 1);
    chk("ldb_dir_bcyc", c_bld, 9);
    chk("ldb_dir_ald", n_ald, 0);

    run(8'h98, 4'h0, 8);
    chk("str_exec", last,
      mk(0,0,0,0,0,0,0,4'd0,2'd3,2'd0,1,0));

    run(8'h96, 4'h0, 7);
    chk("sta_mar_state", last,
      mk(0,1,0,0,0,0,0,4'd0,2'd0,2'd2,0,0));
    reset = 1'b0;
    #1 chk("abort_async", ctl, f0);
    w_abort = 0;
    repeat (3) begin
      @(negedge clk);
      if (write) w_abort++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    run(8'h86, 4'h0, 7);
    chk("abort_writes", w_abort + n_wr, 0);

`ifdef HALT_ON_ILLEGAL_EN
    run(8'hFF, 4'h0, 12);
    chk("halt_cycles", n_halt, 8);
    chk("halt_state", last,
      mk(0,0,0,0,0,0,0,4'd0,2'd0,2'd0,0,1));
    reset = 1'b0;
    #1 chk("halt_reset", ctl, f0);
    @(posedge clk);
    #1 reset = 1'b1;
`else
    run(8'hFF, 4'h0, 5);
    chk("illegal_nop", last, 17'd0);
    chk("illegal_inc", n_inc, 1);
`endif
    run(8'h86, 4'h0, 7);
    chk("after_illegal", n_ald, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
